if_id_control: RTL and testbench
================================

Name: if_id_control

Overview:
- IF/ID pipeline register plus the front-end control unit that answers the fetch stage.
- Latches the fetched instruction, PC and PCPlus1, and decodes control flow in ID: beq, bne, j, jal, jr.
- Drives the fetch redirect inputs: PCsrc, jump, jr, jaddress, adderResult, reg1Addr. Drives hold for data hazards on ID-resolved branches, jr and load-use.
- Squashes the wrong-path instruction after a redirect and keeps saturating stall/flush counters for debug.

Parameters:
- DELAY_SLOT, 0, 1 = the instruction after a taken branch/jump executes; 0 = it is squashed into IF/ID as a bubble.
- CNT_W, 16, width of the saturating stall and flush counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instruction  in  32  fetched instruction for PC, valid every cycle
- PC  in  10  current fetch PC
- PCPlus1  in  10  fetch PC+1
- rsData  in  32  forwarded rs value of the ID instruction
- rtData  in  32  forwarded rt value of the ID instruction
- ex_regWrite  in  1  instruction in EX writes a register
- ex_memRead  in  1  instruction in EX is a load
- ex_rd  in  5  EX destination register
- mem_memRead  in  1  instruction in MEM is a load
- mem_rd  in  5  MEM destination register
- PCsrc  out  1  select branch target
- jump  out  1  select jump/jr path
- jr  out  1  select reg1Addr over jaddress
- jaddress  out  10  instr[9:0] of j/jal in ID
- adderResult  out  10  branch target
- reg1Addr  out  10  rsData[9:0]
- hold  out  1  freeze fetch PC
- id_instruction  out  32  IF/ID instruction
- id_PC  out  10  IF/ID PC
- id_PCPlus1  out  10  IF/ID PCPlus1
- id_valid  out  1  IF/ID holds a real instruction
- id_bubble  out  1  ID must issue a NOP to EX this cycle
- stall_cnt  out  CNT_W  saturating count of hold cycles
- flush_cnt  out  CNT_W  saturating count of squashes

Behaviour:
- Reset: IF/ID registers = 0, id_valid = 0, both counters = 0.
  - Redirect outputs are combinational from IF/ID, so they are 0 while id_valid = 0.
  - A reset mid-stall or mid-redirect discards everything. The first edge after rst deasserts loads instruction/PC normally.
- Decode, only when id_valid = 1 (op = instr[31:26], funct = instr[5:0]):
  - beq: op 0x04. bne: op 0x05. j: op 0x02. jal: op 0x03. jr: op 0x00 with funct 0x08.
- Targets:
  - adderResult = id_PCPlus1 + instr[9:0], mod 2^10, wrap-around allowed.
  - jaddress = instr[9:0].
  - reg1Addr = rsData[9:0].
- Taken conditions:
  - beq taken iff rsData == rtData (full 32-bit compare).
  - bne taken iff rsData != rtData.
- Hazard, combinational. hold = 1 when any of the following holds:
  - (a) load-use: ex_memRead and ex_rd != 0 and ex_rd is rs, or rt for R-type/beq/bne/sw.
  - (b) beq/bne/jr in ID and ex_regWrite and ex_rd != 0 and ex_rd matches a used source.
  - (c) beq/bne/jr in ID and mem_memRead and mem_rd != 0 and mem_rd matches a used source.
  - Register 0 never hazards.
  - A load feeding a branch therefore stalls exactly 2 cycles; an ALU producer stalls 1.
- While hold = 1:
  - PCsrc = jump = jr = 0 (stall beats redirect).
  - IF/ID keeps its contents; id_bubble = 1.
  - stall_cnt increments, saturating at all ones.
- Redirect when hold = 0:
  - taken beq/bne: PCsrc = 1.
  - j/jal: jump = 1, jr = 0.
  - jr: jump = 1, jr = 1.
  - Redirect outputs are valid in the same cycle; fetch takes the target on the next edge.
- Squash:
  - On a redirect edge with DELAY_SLOT = 0, IF/ID loads id_instruction = 0 and id_valid = 0; flush_cnt increments, saturating.
  - With DELAY_SLOT = 1, the edge loads the fetched instruction normally.
- Normal edge (no hold): IF/ID <= instruction, PC, PCPlus1; id_valid <= 1.
- An instruction entering ID from a squash has id_valid = 0, so it can never redirect or hold.

Test Plan:
- Straight line, PC 0..3 with addi instructions -> id_valid = 1 from the cycle after reset release; id_PC tracks 0,1,2,3; all redirects and hold stay 0.
- beq at PC 4, imm 5, rsData = rtData = 7, DELAY_SLOT = 0 -> PCsrc = 1 and adderResult = 10 in ID cycle; next cycle id_valid = 0; then id_PC = 10; flush_cnt = 1.
- lw r3 in EX, then beq r3,r0 in ID -> hold = 1 for exactly 2 cycles, PCsrc = 0 during hold, stall_cnt = 2; branch resolves in the 3rd cycle.
- jr r31 with rsData = 0x3FF -> jump = 1, jr = 1, reg1Addr = 1023; bne at PC 1020 with imm 10 -> adderResult = 7 (wrap-around).
- add r0 in EX with beq r0,r0 in ID -> no hold; rst asserted during a hold -> next cycle id_valid = 0 and counters = 0.
- DELAY_SLOT = 1 with j to 0x20 at PC 8 -> the instruction at PC 9 enters ID with id_valid = 1; flush_cnt stays 0.

Source files
------------

// File: rtl/if_id_control.sv
// IF/ID pipeline register with the front-end control unit.
// Decodes beq/bne/j/jal/jr in ID, drives the fetch redirect controls,
// raises hold on data hazards against ID-resolved control flow and on
// load-use, squashes the wrong-path slot when DELAY_SLOT = 0, and keeps
// saturating stall/flush counters for debug.
module if_id_control #(
  parameter bit DELAY_SLOT = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic [9:0]       PC,
  input  logic [9:0]       PCPlus1,
  input  logic [31:0]      rsData,
  input  logic [31:0]      rtData,
  input  logic             ex_regWrite,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             mem_memRead,
  input  logic [4:0]       mem_rd,
  output logic             PCsrc,
  output logic             jump,
  output logic             jr,
  output logic [9:0]       jaddress,
  output logic [9:0]       adderResult,
  output logic [9:0]       reg1Addr,
  output logic             hold,
  output logic [31:0]      id_instruction,
  output logic [9:0]       id_PC,
  output logic [9:0]       id_PCPlus1,
  output logic             id_valid,
  output logic             id_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      r_instr;
  logic [9:0]       r_pc;
  logic [9:0]       r_pcp1;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_is_beq;
  logic       w_is_bne;
  logic       w_is_j;
  logic       w_is_jr;
  logic       w_is_ctl;
  logic       w_uses_rt;
  logic       w_load_use;
  logic       w_ex_ctl_haz;
  logic       w_mem_ctl_haz;
  logic       w_hold;
  logic       w_taken;
  logic       w_redirect;

  // Decode of the ID instruction; everything is gated by id_valid so a
  // bubble can never redirect or stall.
  always_comb begin
    w_op      = r_instr[31:26];
    w_funct   = r_instr[5:0];
    w_rs      = r_instr[25:21];
    w_rt      = r_instr[20:16];
    w_is_beq  = r_valid && (w_op == OP_BEQ);
    w_is_bne  = r_valid && (w_op == OP_BNE);
    w_is_j    = r_valid && ((w_op == OP_J) || (w_op == OP_JAL));
    w_is_jr   = r_valid && (w_op == OP_RTYPE) && (w_funct == FN_JR);
    w_is_ctl  = w_is_beq || w_is_bne || w_is_jr;
    w_uses_rt = (w_op == OP_RTYPE) || (w_op == OP_BEQ) ||
                (w_op == OP_BNE) || (w_op == OP_SW);
  end

  // Hazard detection: register 0 is excluded; branches compare rs and rt,
  // jr only reads rs.
  always_comb begin
    w_load_use    = r_valid && ex_memRead && (ex_rd != 5'd0) &&
                    ((ex_rd == w_rs) || (w_uses_rt && (ex_rd == w_rt)));
    w_ex_ctl_haz  = w_is_ctl && ex_regWrite && (ex_rd != 5'd0) &&
                    ((ex_rd == w_rs) ||
                     ((w_is_beq || w_is_bne) && (ex_rd == w_rt)));
    w_mem_ctl_haz = w_is_ctl && mem_memRead && (mem_rd != 5'd0) &&
                    ((mem_rd == w_rs) ||
                     ((w_is_beq || w_is_bne) && (mem_rd == w_rt)));
    w_hold        = w_load_use || w_ex_ctl_haz || w_mem_ctl_haz;
  end

  // Redirect controls; a stall always wins over a redirect.
  always_comb begin
    w_taken     = (w_is_beq && (rsData == rtData)) ||
                  (w_is_bne && (rsData != rtData));
    PCsrc       = !w_hold && w_taken;
    jump        = !w_hold && (w_is_j || w_is_jr);
    jr          = !w_hold && w_is_jr;
    w_redirect  = PCsrc || jump;
    jaddress    = r_valid ? r_instr[9:0] : 10'd0;
    adderResult = r_valid ? (r_pcp1 + r_instr[9:0]) : 10'd0;
    reg1Addr    = r_valid ? rsData[9:0] : 10'd0;
    hold        = w_hold;
    id_bubble   = w_hold;
  end

  // IF/ID register: hold freezes it, a redirect squashes the slot unless
  // the delay slot is architectural.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= 32'd0;
      r_pc    <= 10'd0;
      r_pcp1  <= 10'd0;
      r_valid <= 1'b0;
    end else if (!w_hold) begin
      r_pc   <= PC;
      r_pcp1 <= PCPlus1;
      if (w_redirect && !DELAY_SLOT) begin
        r_instr <= 32'd0;
        r_valid <= 1'b0;
      end else begin
        r_instr <= instruction;
        r_valid <= 1'b1;
      end
    end
  end

  // Saturating debug counters for hold cycles and squashes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_hold && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redirect && !DELAY_SLOT && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign id_instruction = r_instr;
  assign id_PC          = r_pc;
  assign id_PCPlus1     = r_pcp1;
  assign id_valid       = r_valid;
  assign stall_cnt      = r_stall_cnt;
  assign flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_if_id_control.sv
// Directed bench for if_id_control. Two instances share all inputs:
// d0 squashes after redirects (16-bit counters), d1 has an architectural
// delay slot and 2-bit counters so saturation is reachable.
module tb_if_id_control;

  localparam logic [31:0] ADDI = 32'h20010001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [9:0]  PC, PCPlus1;
  logic [31:0] rsData, rtData;
  logic        ex_regWrite, ex_memRead, mem_memRead;
  logic [4:0]  ex_rd, mem_rd;

  logic        d0_PCsrc, d0_jump, d0_jr, d0_hold, d0_valid, d0_bubble;
  logic [9:0]  d0_jaddr, d0_add, d0_r1, d0_pc, d0_pcp1;
  logic [31:0] d0_instr;
  logic [15:0] d0_stall, d0_flush;
  logic        d1_PCsrc, d1_jump, d1_jr, d1_hold, d1_valid, d1_bubble;
  logic [9:0]  d1_jaddr, d1_add, d1_r1, d1_pc, d1_pcp1;
  logic [31:0] d1_instr;
  logic [1:0]  d1_stall, d1_flush;

  int pass_cnt = 0;
  int total    = 0;

  if_id_control #(.DELAY_SLOT(1'b0), .CNT_W(16)) u_d0 (
    .clk(clk), .rst(rst), .instruction(instruction), .PC(PC), .PCPlus1(PCPlus1),
    .rsData(rsData), .rtData(rtData), .ex_regWrite(ex_regWrite),
    .ex_memRead(ex_memRead), .ex_rd(ex_rd), .mem_memRead(mem_memRead),
    .mem_rd(mem_rd), .PCsrc(d0_PCsrc), .jump(d0_jump), .jr(d0_jr),
    .jaddress(d0_jaddr), .adderResult(d0_add), .reg1Addr(d0_r1),
    .hold(d0_hold), .id_instruction(d0_instr), .id_PC(d0_pc),
    .id_PCPlus1(d0_pcp1), .id_valid(d0_valid), .id_bubble(d0_bubble),
    .stall_cnt(d0_stall), .flush_cnt(d0_flush)
  );

  if_id_control #(.DELAY_SLOT(1'b1), .CNT_W(2)) u_d1 (
    .clk(clk), .rst(rst), .instruction(instruction), .PC(PC), .PCPlus1(PCPlus1),
    .rsData(rsData), .rtData(rtData), .ex_regWrite(ex_regWrite),
    .ex_memRead(ex_memRead), .ex_rd(ex_rd), .mem_memRead(mem_memRead),
    .mem_rd(mem_rd), .PCsrc(d1_PCsrc), .jump(d1_jump), .jr(d1_jr),
    .jaddress(d1_jaddr), .adderResult(d1_add), .reg1Addr(d1_r1),
    .hold(d1_hold), .id_instruction(d1_instr), .id_PC(d1_pc),
    .id_PCPlus1(d1_pcp1), .id_valid(d1_valid), .id_bubble(d1_bubble),
    .stall_cnt(d1_stall), .flush_cnt(d1_flush)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [9:0] pc);
    instruction = ins;
    PC          = pc;
    PCPlus1     = pc + 10'd1;
  endtask

  task automatic clear_haz();
    ex_regWrite = 1'b0;
    ex_memRead  = 1'b0;
    ex_rd       = 5'd0;
    mem_memRead = 1'b0;
    mem_rd      = 5'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    rsData = 32'd0;
    rtData = 32'd0;
    clear_haz();
    fetch(ADDI, 10'd0);
    tick();
    tick();
    settle();
    check("rst_valid", {31'd0, d0_valid}, 32'd0);
    check("rst_instr", d0_instr, 32'd0);
    check("rst_stall", {16'd0, d0_stall}, 32'd0);
    check("rst_flush", {16'd0, d0_flush}, 32'd0);
    check("rst_redir", {29'd0, d0_PCsrc, d0_jump, d0_hold}, 32'd0);

    // Straight-line addi sequence
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch(ADDI, 10'(i));
      tick();
      settle();
      check("line_pc", {22'd0, d0_pc}, 32'(i));
      check("line_pcp1", {22'd0, d0_pcp1}, 32'(i + 1));
      check("line_valid", {31'd0, d0_valid}, 32'd1);
      check("line_ctl", {29'd0, d0_PCsrc, d0_jump, d0_hold}, 32'd0);
    end

    // beq r1,r2,5 at PC 4, taken
    fetch(32'h10220005, 10'd4);
    rsData = 32'd7;
    rtData = 32'd7;
    tick();
    settle();
    check("beq_pcsrc", {31'd0, d0_PCsrc}, 32'd1);
    check("beq_target", {22'd0, d0_add}, 32'd10);
    check("beq_nohold", {30'd0, d0_hold, d0_jump}, 32'd0);
    fetch(ADDI, 10'd5);
    tick();
    settle();
    check("sq_valid", {31'd0, d0_valid}, 32'd0);
    check("sq_instr", d0_instr, 32'd0);
    check("sq_flush", {16'd0, d0_flush}, 32'd1);
    check("sq_pcsrc", {31'd0, d0_PCsrc}, 32'd0);
    check("ds_valid", {31'd0, d1_valid}, 32'd1);
    check("ds_pc", {22'd0, d1_pc}, 32'd5);
    check("ds_flush", {30'd0, d1_flush}, 32'd0);
    fetch(ADDI, 10'd10);
    tick();
    settle();
    check("tgt_pc", {22'd0, d0_pc}, 32'd10);
    check("tgt_valid", {31'd0, d0_valid}, 32'd1);

    // lw r3 in EX, then MEM, against beq r3,r0,2 at PC 11
    fetch(32'h10600002, 10'd11);
    tick();
    ex_memRead = 1'b1;
    ex_regWrite = 1'b1;
    ex_rd = 5'd3;
    rsData = 32'd0;
    rtData = 32'd0;
    settle();
    check("lu1_hold", {31'd0, d0_hold}, 32'd1);
    check("lu1_pcsrc", {31'd0, d0_PCsrc}, 32'd0);
    check("lu1_bubble", {31'd0, d0_bubble}, 32'd1);
    fetch(ADDI, 10'd12);
    tick();
    clear_haz();
    mem_memRead = 1'b1;
    mem_rd = 5'd3;
    settle();
    check("lu2_pc", {22'd0, d0_pc}, 32'd11);
    check("lu2_hold", {31'd0, d0_hold}, 32'd1);
    check("lu2_pcsrc", {31'd0, d0_PCsrc}, 32'd0);
    check("lu2_stall", {16'd0, d0_stall}, 32'd1);
    tick();
    clear_haz();
    settle();
    check("lu3_hold", {31'd0, d0_hold}, 32'd0);
    check("lu3_pcsrc", {31'd0, d0_PCsrc}, 32'd1);
    check("lu3_target", {22'd0, d0_add}, 32'd14);
    check("lu3_stall", {16'd0, d0_stall}, 32'd2);
    check("lu3_bubble", {31'd0, d0_bubble}, 32'd0);
    tick();
    settle();
    check("lu_flush", {16'd0, d0_flush}, 32'd2);
    check("lu_sqvalid", {31'd0, d0_valid}, 32'd0);

    // jr r31 with rsData = 0x3FF
    fetch(32'h03E00008, 10'd14);
    tick();
    rsData = 32'h0000_03FF;
    settle();
    check("jr_jump", {31'd0, d0_jump}, 32'd1);
    check("jr_jr", {31'd0, d0_jr}, 32'd1);
    check("jr_reg1", {22'd0, d0_r1}, 32'd1023);
    check("jr_pcsrc", {31'd0, d0_PCsrc}, 32'd0);
    fetch(ADDI, 10'd15);
    tick();
    // bne r1,r2,10 at PC 1020, target wraps to 7
    fetch(32'h1422000A, 10'd1020);
    rsData = 32'd1;
    rtData = 32'd2;
    tick();
    settle();
    check("bne_pcsrc", {31'd0, d0_PCsrc}, 32'd1);
    check("bne_wrap", {22'd0, d0_add}, 32'd7);
    check("bne_jump", {31'd0, d0_jump}, 32'd0);
    fetch(ADDI, 10'd1021);
    tick();
    fetch(ADDI, 10'd7);
    tick();
    settle();
    check("wrap_pc", {22'd0, d0_pc}, 32'd7);
    check("wrap_flush", {16'd0, d0_flush}, 32'd4);

    // beq r0,r0 with r0 writers in EX: no hazard
    fetch(32'h10000001, 10'd8);
    rsData = 32'd0;
    rtData = 32'd0;
    tick();
    ex_regWrite = 1'b1;
    ex_memRead = 1'b1;
    ex_rd = 5'd0;
    settle();
    check("r0_hold", {31'd0, d0_hold}, 32'd0);
    check("r0_pcsrc", {31'd0, d0_PCsrc}, 32'd1);
    clear_haz();
    fetch(ADDI, 10'd9);
    tick();

    // ALU producer r3 against beq r3,r0: extended hold, then reset mid-stall
    fetch(32'h10600001, 10'd9);
    tick();
    ex_regWrite = 1'b1;
    ex_rd = 5'd3;
    settle();
    check("alu_hold", {31'd0, d0_hold}, 32'd1);
    check("alu_stall0", {16'd0, d0_stall}, 32'd2);
    tick();
    settle();
    check("alu_stall1", {16'd0, d0_stall}, 32'd3);
    check("sat_stall1", {30'd0, d1_stall}, 32'd3);
    tick();
    settle();
    check("alu_stall2", {16'd0, d0_stall}, 32'd4);
    check("sat_stall2", {30'd0, d1_stall}, 32'd3);
    rst = 1'b1;
    tick();
    settle();
    check("mrst_valid", {31'd0, d0_valid}, 32'd0);
    check("mrst_stall", {16'd0, d0_stall}, 32'd0);
    check("mrst_flush", {16'd0, d0_flush}, 32'd0);
    check("mrst_hold", {31'd0, d0_hold}, 32'd0);
    check("mrst_instr", d0_instr, 32'd0);
    rst = 1'b0;
    clear_haz();

    // j 0x20 at PC 8: delay slot kept in d1, squashed in d0
    fetch(32'h08000020, 10'd8);
    tick();
    settle();
    check("j_jump", {31'd0, d0_jump}, 32'd1);
    check("j_jr", {31'd0, d0_jr}, 32'd0);
    check("j_addr", {22'd0, d0_jaddr}, 32'h20);
    fetch(ADDI, 10'd9);
    tick();
    settle();
    check("jds_valid", {31'd0, d1_valid}, 32'd1);
    check("jds_pc", {22'd0, d1_pc}, 32'd9);
    check("jds_flush", {30'd0, d1_flush}, 32'd0);
    check("jsq_valid", {31'd0, d0_valid}, 32'd0);
    check("jsq_flush", {16'd0, d0_flush}, 32'd1);
    fetch(ADDI, 10'h20);
    tick();
    settle();
    check("jtgt_pc", {22'd0, d0_pc}, 32'h20);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
